clkdiv_multi: RTL

//  Multi-channel programmable clock-enable generator; successor to the single fixed-divisor divider.

---
 rtl/clkdiv_multi.sv | 97 +++++++++
 1 files changed

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable generator: per-channel tick strobe and toggle output,
// with glitch-free divisor reload. Optional phase-sync input under CLKDIV_PHASE_SYNC_EN.
module clkdiv_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 250000,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic              sync,
`endif
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic              div_ack,
  output logic              div_err,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_div
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [CNT_W-1:0]  div    [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic              do_sync;
  logic              wr_ok;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign do_sync = sync;
`else
  assign do_sync = 1'b0;
`endif

  assign wr_ok = div_wr && (div_data != '0) && ({1'b0, div_sel} < CH_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        div[i]    <= DIV_RST;
        shadow[i] <= DIV_RST;
      end
      pend    <= '0;
      tick    <= '0;
      clk_div <= '0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_ack <= wr_ok;
      div_err <= div_wr && !wr_ok;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (do_sync) begin
          count[i]   <= '0;
          clk_div[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pend[i]) begin
            div[i]  <= shadow[i];
            pend[i] <= 1'b0;
          end
        end else if (en[i]) begin
          if (count[i] == div[i] - CNT_W'(1)) begin
            count[i]   <= '0;
            tick[i]    <= 1'b1;
            clk_div[i] <= ~clk_div[i];
            // Reload only at the wrap so the period just ending keeps the old divisor.
            if (pend[i]) begin
              div[i]  <= shadow[i];
              pend[i] <= 1'b0;
            end
          end else begin
            count[i] <= count[i] + CNT_W'(1);
            tick[i]  <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
          if (pend[i]) begin
            div[i]   <= shadow[i];
            count[i] <= '0;
            pend[i]  <= 1'b0;
          end
        end
        // Placed last so a write in the same cycle as a reload re-arms pend for the next one.
        if (wr_ok && (div_sel == SEL_W'(i))) begin
          shadow[i] <= div_data;
          pend[i]   <= 1'b1;
        end
      end
    end
  end

endmodule
